// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma - $4014 sprite DMA bus initiator.
//
// A write to $4014 halts the CPU and copies 256 bytes from page XX00..XXFF
// to OAMDATA ($2004) as alternating read/write accesses on the shared
// memreq/memack bus. At most one access is started per CPU tick.
//
// Optional feature macro: OAM_DMA_ALIGN_EN
//   defined   : an ALIGN state adds one tick when the trigger lands on an
//               odd CPU cycle (513/514-tick cycle-accurate timing).
//   undefined : HALT goes straight to RD; fixed 513 ticks, no parity flop.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   tick      in   CPU-cycle enable
//   dmawr     in   one-clk strobe: CPU wrote $4014
//   dmapage   in   [7:0] source page
//   cpuhalt   out  holds the CPU while the DMA owns the bus
//   memaddr   out  [15:0] bus address
//   memwdata  out  [7:0] write data
//   memwr     out  1 = write, 0 = read
//   memreq    out  request; responder acts on its rising edge
//   memack    in   one-clk acknowledge
//   memrdata  in   [7:0] read data, valid with memack
//   dmabusy   out  high from accepted trigger until DONE
// ---------------------------------------------------------------------------
module oam_dma #(
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
  parameter int unsigned LEN          = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        dmawr,
  input  logic [7:0]  dmapage,
  output logic        cpuhalt,
  output logic [15:0] memaddr,
  output logic [7:0]  memwdata,
  output logic        memwr,
  output logic        memreq,
  input  logic        memack,
  input  logic [7:0]  memrdata,
  output logic        dmabusy
);

  localparam logic [8:0] LEN_C = 9'(LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_RD    = 3'd3,
    S_RDW   = 3'd4,
    S_WR    = 3'd5,
    S_WRW   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  count_q, count_d;
  logic [7:0]  page_q, page_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        req_q, req_d;
  logic        halt_q, halt_d;
  logic        busy_q, busy_d;

`ifdef OAM_DMA_ALIGN_EN
  logic parity_q, parity_d;

  // CPU-cycle parity: free-running toggle on every tick, independent of DMA.
  always_comb begin
    if (tick) begin
      parity_d = ~parity_q;
    end else begin
      parity_d = parity_q;
    end
  end

  // Parity register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // Next-state and registered-output computation for the DMA sequencer.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    page_d  = page_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    req_d   = req_q;
    halt_d  = halt_q;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        if (dmawr) begin
          page_d  = dmapage;
          count_d = 9'd0;
          busy_d  = 1'b1;
          halt_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_IDLE;
        end
      end
      // The first halted tick is the dummy cycle.
      S_HALT: begin
        if (tick) begin
`ifdef OAM_DMA_ALIGN_EN
          if (parity_q) begin
            state_d = S_ALIGN;
          end else begin
            state_d = S_RD;
          end
`else
          state_d = S_RD;
`endif
        end else begin
          state_d = S_HALT;
        end
      end
`ifdef OAM_DMA_ALIGN_EN
      S_ALIGN: begin
        if (tick) begin
          state_d = S_RD;
        end else begin
          state_d = S_ALIGN;
        end
      end
`endif
      S_RD: begin
        if (tick) begin
          addr_d  = {page_q, count_q[7:0]};
          wr_d    = 1'b0;
          req_d   = 1'b1;
          state_d = S_RDW;
        end else begin
          state_d = S_RD;
        end
      end
      // Request and address held until acknowledged; the next access waits
      // for a later tick, which guarantees a low clk on memreq in between.
      S_RDW: begin
        if (memack && req_q) begin
          wdata_d = memrdata;
          req_d   = 1'b0;
          state_d = S_WR;
        end else begin
          state_d = S_RDW;
        end
      end
      S_WR: begin
        if (tick) begin
          addr_d  = OAMDATA_ADDR;
          wr_d    = 1'b1;
          req_d   = 1'b1;
          state_d = S_WRW;
        end else begin
          state_d = S_WR;
        end
      end
      // The low byte wraps inside the page; termination uses all 9 bits.
      S_WRW: begin
        if (memack && req_q) begin
          req_d   = 1'b0;
          count_d = count_q + 9'd1;
          if (count_d == LEN_C) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = S_WRW;
        end
      end
      S_DONE: begin
        halt_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        halt_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= 9'd0;
      page_q  <= 8'd0;
      addr_q  <= 16'd0;
      wdata_q <= 8'd0;
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
      halt_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      page_q  <= page_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      req_q   <= req_d;
      halt_q  <= halt_d;
      busy_q  <= busy_d;
    end
  end

  assign cpuhalt  = halt_q;
  assign memaddr  = addr_q;
  assign memwdata = wdata_q;
  assign memwr    = wr_q;
  assign memreq   = req_q;
  assign dmabusy  = busy_q;

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-bus initiator that performs the $4014 sprite DMA.
- On a write to $4014 it halts the CPU, then issues 256 read/write pairs on the PPU/CPU memory bus: read from page XX00..XXFF, write to $2004 (OAMDATA).
- Drives the memreq/memack initiator side that the PPU register block responds to.
- Sits beside the CPU core, and its requests are multiplexed onto the bus while cpuhalt is high.

Parameters:
- OAMDATA_ADDR, 16'h2004, target address for every DMA write.
- LEN, 256, number of bytes transferred (9-bit count; 1..256).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  CPU-cycle enable; one bus access maximum per tick.
- dmawr  in  1  one-clk strobe: CPU wrote $4014.
- dmapage  in  8  data written to $4014 (source page).
- cpuhalt  out  1  holds the CPU while DMA is active.
- memaddr  out  16  bus address.
- memwdata  out  8  write data.
- memwr  out  1  1 = write, 0 = read.
- memreq  out  1  request; the responder acts on its rising edge.
- memack  in  1  one-clk acknowledge from the responder.
- memrdata  in  8  read data, valid with memack.
- dmabusy  out  1  high from accepted trigger until DONE.

Behaviour:
- Interface (already decided): one clock `clk`; `reset` is asynchronous and active-low.
- Reset values (all outputs forced asynchronously): cpuhalt=0, memreq=0, memwr=0, memaddr=0, memwdata=0, dmabusy=0; state=IDLE; byte count=0; parity flop=0.
- Parity flop: toggles on every tick; it is not cleared by DMA.
- IDLE: on dmawr, latch dmapage, clear the count, set dmabusy=1 and cpuhalt=1, go to HALT. dmawr in any other state is ignored.
- HALT: on the next tick, the dummy cycle is consumed; go to ALIGN if parity=1, otherwise go to RD.
- ALIGN: on the next tick, go to RD.
- RD: on a tick, drive memaddr={page,count[7:0]}, memwr=0, memreq=1; go to RDW.
- RDW: memreq stays high and the address stays stable until memack. On the memack clk, latch memrdata into memwdata, drop memreq, go to WR.
- WR: on a tick, drive memaddr=OAMDATA_ADDR, memwr=1, memreq=1; go to WRW.
- WRW: on memack, drop memreq and increment count. If count reaches LEN, go to DONE; otherwise go to RD.
- DONE: cpuhalt=0 and dmabusy=0 in the same clk; go to IDLE.
- Handshake rules:
  - memreq is low for at least one clk between accesses, so every access presents a fresh rising edge.
  - A new access never starts in the clk memack arrives.
  - If memack arrives after the following tick, that tick is skipped; no access is dropped or duplicated.
  - memack seen while memreq=0 is ignored.
- Timing: with memack in the clk after memreq rises, the transfer occupies 1 + parity + 2*LEN ticks, i.e. 513 or 514 for LEN=256.
- Count wrap: the low 8 bits wrap within the page (page XX does not carry into XX+1); termination uses the 9-bit count.
- Reset mid-operation: memreq and cpuhalt drop immediately; the partial transfer is abandoned.

Optional Feature:
- Macro: `OAM_DMA_ALIGN_EN`.
- Defined: the ALIGN state exists; an odd-parity start adds one tick, giving 513/514-tick cycle-accurate timing.
- Undefined: HALT always goes directly to RD; the duration is fixed at 513 ticks and the parity flop is not synthesized.

Test Plan:
1. Even parity, dmawr with dmapage=8'h02, memack 1 clk after each rise, memory[0x02nn]=nn^8'hA5 -> 256 reads 0x0200..0x02FF alternating with writes to 0x2004 carrying nn^8'hA5; cpuhalt high for exactly 513 ticks.
2. Same as test 1 but with parity=1 at trigger -> 514 ticks (`OAM_DMA_ALIGN_EN` defined); 513 with the macro undefined.
3. memack delayed 5 ticks on the read of 0x0210 -> memaddr held stable; memreq stays 1 until the ack; the next write goes to 0x2004 with the correct data; no extra or missing access; total ticks increase by the delay.
4. Second dmawr (page 8'h07) at byte 100 -> ignored; all addresses stay in page 0x02; dmabusy drops once.
5. memreq edge check -> memreq low for ≥1 clk between every pair of consecutive accesses; 512 rising edges total.
6. reset asserted low at byte 40 during RDW -> memreq=0 and cpuhalt=0 asynchronously. After release, a new dmawr with page 8'h03 starts from 0x0300.
